// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, reset level and FSM states.
package lsu_pkg;

    localparam int ALU_OP_BUS = 5;

    localparam logic [ALU_OP_BUS-1:0] ALU_OP_ADD = 5'd0;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_SUB = 5'd1;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_LB  = 5'd8;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_LH  = 5'd9;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_LW  = 5'd10;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_LBU = 5'd11;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_LHU = 5'd12;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_SB  = 5'd13;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_SH  = 5'd14;
    localparam logic [ALU_OP_BUS-1:0] ALU_OP_SW  = 5'd15;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_load(input logic [ALU_OP_BUS-1:0] op);
        case (op)
            ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_LBU, ALU_OP_LHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_is_store(input logic [ALU_OP_BUS-1:0] op);
        case (op)
            ALU_OP_SB, ALU_OP_SH, ALU_OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Halfword ops need an even address, word ops need a word-aligned one.
    function automatic logic lsu_misaligned(input logic [ALU_OP_BUS-1:0] op,
                                            input logic [1:0] addr_lo);
        case (op)
            ALU_OP_LH, ALU_OP_LHU, ALU_OP_SH: return addr_lo[0];
            ALU_OP_LW, ALU_OP_SW:             return (addr_lo != 2'b00);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load expansion: selects a byte/halfword/word of the read word and
// sign- or zero-extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [ALU_OP_BUS-1:0] alu_op_i,
    input  logic [1:0]            offset_i,
    input  logic [31:0]           rdata_i,
    output logic [31:0]           data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Extend the selected lane according to the op.
    always_comb begin
        data_o = ZERO_WORD;
        case (alu_op_i)
            ALU_OP_LB:  data_o = {{24{byte_s[7]}}, byte_s};
            ALU_OP_LBU: data_o = {24'h00_0000, byte_s};
            ALU_OP_LH:  data_o = {{16{half_s[15]}}, half_s};
            ALU_OP_LHU: data_o = {16'h0000, half_s};
            ALU_OP_LW:  data_o = rdata_i;
            default:    data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/gnt/rsp data-memory port with registered outputs.
// Optional build macro: LSU_MISALIGN_CHECK_EN aborts misaligned halfword/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ALU_OP_BUS-1:0] alu_op_i,
    input  logic [31:0]           alu_result_i,
    input  logic [31:0]           rmem_addr_i,
    input  logic [31:0]           wmem_addr_i,
    input  logic [7:0]            wmem_mask_i,
    input  logic [31:0]           store_data_i,
    input  logic [31:0]           read_offset_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [7:0]            mem_wmask_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_data_o,
    output logic                  err_o
);

    localparam int   CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    lsu_state_e            state_q;
    logic                  in_ready_q, mem_req_q, mem_we_q, out_valid_q, err_q;
    logic [31:0]           mem_addr_q, mem_wdata_q, out_data_q;
    logic [7:0]            mem_wmask_q;
    logic [ALU_OP_BUS-1:0] op_q;
    logic [1:0]            off_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  is_load_d, is_store_d, misalign_d;
    logic [31:0]           addr_d, rsp_data_d, ext_d;
    logic                  unused_offset_s;

    assign unused_offset_s = ^read_offset_i[31:2];
    assign is_load_d  = lsu_is_load(alu_op_i);
    assign is_store_d = lsu_is_store(alu_op_i);
    assign addr_d     = is_store_d ? wmem_addr_i : rmem_addr_i;
`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign_d = lsu_misaligned(alu_op_i, addr_d[1:0]);
`else
    assign misalign_d = 1'b0;
`endif

    load_extend u_load_extend (
        .alu_op_i (op_q),
        .offset_i (off_q),
        .rdata_i  (mem_rdata_i),
        .data_o   (ext_d)
    );

    // A store's response is only an acknowledge, so it writes back zero.
    assign rsp_data_d = mem_we_q ? ZERO_WORD : ext_d;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= LSU_IDLE;
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ZERO_WORD;
            mem_wdata_q <= ZERO_WORD;
            mem_wmask_q <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= ZERO_WORD;
            err_q       <= 1'b0;
            op_q        <= ALU_OP_ADD;
            off_q       <= 2'b00;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (in_valid_i) begin
                        in_ready_q <= 1'b0;
                        if ((is_load_d || is_store_d) && misalign_d) begin
                            state_q     <= LSU_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= ZERO_WORD;
                            err_q       <= 1'b1;
                        end else if (is_load_d || is_store_d) begin
                            state_q     <= LSU_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_d;
                            mem_addr_q  <= {addr_d[31:2], 2'b00};
                            mem_wdata_q <= is_store_d ? (store_data_i << {wmem_addr_i[1:0], 3'b000})
                                                      : ZERO_WORD;
                            mem_wmask_q <= wmem_mask_i;
                            op_q        <= alu_op_i;
                            off_q       <= read_offset_i[1:0];
                        end else begin
                            state_q     <= LSU_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= alu_result_i;
                            err_q       <= 1'b0;
                        end
                    end else begin
                        state_q <= LSU_IDLE;
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt_i && mem_rvalid_i) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= LSU_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rsp_data_d;
                        err_q       <= 1'b0;
                    end else if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= LSU_WAIT;
                        cnt_q     <= CNT_W'(MEM_TIMEOUT);
                    end else begin
                        state_q <= LSU_REQ;
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q     <= LSU_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rsp_data_d;
                        err_q       <= 1'b0;
                    end else if (TIMEOUT_EN && (cnt_q == {CNT_W{1'b0}})) begin
                        state_q     <= LSU_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= ZERO_WORD;
                        err_q       <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= LSU_WAIT;
                    end
                end
                LSU_DONE: begin
                    if (out_ready_i) begin
                        state_q     <= LSU_IDLE;
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= LSU_DONE;
                    end
                end
                default: begin
                    state_q     <= LSU_IDLE;
                    in_ready_q  <= 1'b1;
                    mem_req_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage and upstream of write-back. Registers one execute-stage result per transaction and drives a single-outstanding request/grant/response data-memory port. Expands loaded bytes and halfwords, with sign or zero extension, into a 32-bit write-back value. Non-memory ops bypass the bus and complete in one cycle.

## Interface
Parameters:
- MEM_TIMEOUT, 255: cycles to wait in WAIT_RSP before aborting with `err_o`; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (`RST_ENABLE` = 1'b0).
- in_valid_i  in  1  execute result valid.
- in_ready_o  out  1  lsu can accept; high only in IDLE.
- alu_op_i  in  `ALU_OP_BUS`  operation code.
- alu_result_i  in  32  non-memory result.
- rmem_addr_i  in  32  load byte address.
- wmem_addr_i  in  32  store byte address.
- wmem_mask_i  in  8  byte-lane mask from execute, already lane-aligned.
- store_data_i  in  32  rs2 value, unshifted.
- read_offset_i  in  32  load byte offset; only bits [1:0] are used.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_wmask_o  out  8  registered copy of wmem_mask_i.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response valid. Loads return data; stores return an acknowledge.
- mem_rdata_i  in  32  read word.
- out_valid_o  out  1  result to write-back valid.
- out_ready_i  in  1  write-back accepts.
- out_data_o  out  32  write-back value.
- err_o  out  1  transaction aborted; valid only while out_valid_o is high.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - On in_valid_i with a load op (LB/LH/LW/LBU/LHU) or store op (SB/SH/SW): latch all inputs and go to REQ.
  - Any other op: latch alu_result_i into out_data_o and go to DONE.
- REQ: hold mem_req_o=1 and every mem_* output stable until mem_gnt_i. Grant goes to WAIT_RSP. If mem_rvalid_i arrives in the same cycle as the grant, go directly to DONE.
- WAIT_RSP: on mem_rvalid_i, go to DONE.
  - Load: expand the read word into out_data_o.
  - Store: out_data_o = 0.
- DONE: out_valid_o=1 and out_data_o held stable. When out_ready_i is seen, go to IDLE.
- Load expansion, with o = offset[1:0]:
  - LB/LBU select byte o; LH/LHU select halfword o[1]; LW takes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store data: mem_wdata_o = store_data_i << (8*addr[1:0]). Bytes outside the mask are don't-care.
- Timeout: a down-counter loads MEM_TIMEOUT on entry to WAIT_RSP. If it reaches 0 before mem_rvalid_i, go to DONE with err_o=1 and out_data_o=0.
- Late responses: a mem_rvalid_i outside WAIT_RSP (or the same-cycle REQ case) is ignored.

## Timing
- Reset values: state IDLE; in_ready_o=1; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; mem_wmask_o=0; out_valid_o=0; out_data_o=0; err_o=0.
- Reset has priority over all events, including mid-transaction. Any in-flight request is dropped without waiting for a response.
- Non-memory op latency: accept in cycle N, out_valid_o in N+1.
- Memory op latency with zero-wait grant and rvalid one cycle after grant: accept N, mem_req_o N+1, rvalid N+2, out_valid_o N+3.
- Only one transaction is outstanding at a time. in_ready_o is low in every state except IDLE, so the execute stage stalls.
- All outputs are registered. There is no combinational path from in_* to out_*, or from mem_* to out_*.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Checks LH/LHU/SH at an odd address, and LW/SW with addr[1:0]≠0.
  - A misaligned access skips REQ and goes IDLE→DONE with err_o=1 and out_data_o=0. No mem_req_o is issued.
- Undefined: no check. Misaligned access proceeds with the wrapped byte select; the mask comes from wmem_mask_i unchanged.

## Structure
- Shared package/defines: `ALU_OP_*` load/store encodings, `RST_ENABLE`, `ZERO_WORD`, and the FSM state encoding `LSU_IDLE`/`LSU_REQ`/`LSU_WAIT`/`LSU_DONE`.
- One natural sub-module, `load_extend`: purely combinational `(alu_op, offset[1:0], rdata) -> 32-bit`. It is reused by any future cache refill path.

## Test plan
- ADD op with alu_result_i=0x1234 -> out_valid_o next cycle with out_data_o=0x1234; no mem_req_o.
- LB at addr 0x1003, rdata=0x80FF_FF00 -> mem_addr_o=0x1000; out_data_o=0xFFFF_FF80. Same case with LBU -> 0x0000_0080.
- SH at addr 0x2002, data 0xABCD, mask 0x0C -> mem_we_o=1, mem_addr_o=0x2000, mem_wdata_o[31:16]=0xABCD, mem_wmask_o=0x0C.
- mem_gnt_i withheld 5 cycles -> mem_req_o and mem_addr_o stable throughout; in_ready_o=0; completes after grant plus rvalid.
- MEM_TIMEOUT=4 and no rvalid -> out_valid_o with err_o=1 and out_data_o=0. Then rst low mid-LW -> next cycle all outputs at reset values, state IDLE.
- With `LSU_MISALIGN_CHECK_EN`: LW at 0x3001 -> no mem_req_o; out_valid_o and err_o asserted the cycle after accept.
